// File: rtl/gate_sequencer_pkg.sv
// Shared definitions for the gate self-test sequencer: state encodings,
// vector index width and the failing-vector priority helper.
package gate_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_VEC = 2'd3;

  // Lowest set bit of the mismatch mask; 0 when nothing failed.
  function automatic logic [IDX_W-1:0] lowest_fail(input logic [3:0] mask);
    lowest_fail = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_fail = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/gate_sequencer_dwell_timer.sv
// Dwell counter for one test vector: counts 0..DWELL-1 while enabled and
// wraps on its own; last flags the sampling clock of the dwell.
module dwell_timer #(
  parameter int DWELL = 4,
  parameter int CW    = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign last = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Self-test controller for a 2-input gate: walks vectors 00..11, holds each
// for DWELL clocks, samples z0 on the last clock and records mismatches.
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int         DWELL  = 4,
  parameter logic [3:0] EXPECT = 4'b1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       z0,
  output logic       x0,
  output logic       x1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] first_fail
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             timer_clr;
  logic             timer_en;
  logic [3:0]       mask_next;

  // Timer is held cleared outside APPLY so every run starts its first dwell at 0.
  assign timer_clr = (state != ST_APPLY);
  assign timer_en  = (state == ST_APPLY);

  dwell_timer #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (timer_clr),
    .en   (timer_en),
    .last (last)
  );

  always_comb begin
    mask_next = fail_mask;
    if (z0 != EXPECT[idx]) mask_next[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      x0         <= 1'b0;
      x1         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_APPLY;
            idx        <= '0;
            x0         <= 1'b0;
            x1         <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            first_fail <= '0;
          end
        end
        ST_APPLY: begin
          if (last) begin
            fail_mask  <= mask_next;
            first_fail <= lowest_fail(mask_next);
            if (idx == LAST_VEC) begin
              state <= ST_DONE;
              x0    <= 1'b0;
              x1    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_next == 4'b0000);
            end else begin
              idx      <= idx + 1'b1;
              {x0, x1} <= idx + 1'b1;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          idx        <= '0;
          x0         <= 1'b0;
          x1         <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
          fail_mask  <= '0;
          first_fail <= '0;
        end
      endcase
    end
  end

endmodule
